// File: rtl/rv_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_alu_pkg
//  Description : Shared ALU op encoding and op-legality helper for the
//                arbitrated ALU block.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_alu_pkg;

  localparam int c_op_w = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  // True for the six implemented op codes; anything else is flagged as an error
  function automatic logic is_legal_op(input logic [c_op_w-1:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : rv_alu_core
//  Description : Purely combinational ALU. Illegal op codes produce zero so
//                the result is always a defined value.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_alu_core
  import rv_alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]     in1,
  input  logic [DW-1:0]     in2,
  input  logic [c_op_w-1:0] op,
  output logic [DW-1:0]     out,
  output logic              zflag
);

  logic [DW-1:0] w_res;

  // Op decode; SLT is an unsigned compare returned in the LSB
  always_comb begin
    w_res = '0;
    case (op)
      ALU_AND: w_res = in1 & in2;
      ALU_OR:  w_res = in1 | in2;
      ALU_ADD: w_res = in1 + in2;
      ALU_SUB: w_res = in1 - in2;
      ALU_SLT: w_res = {{(DW-1){1'b0}}, (in1 < in2)};
      ALU_NOR: w_res = ~(in1 | in2);
      default: w_res = '0;
    endcase
  end

  assign out   = w_res;
  assign zflag = (w_res == '0);

endmodule
`default_nettype wire

// File: rtl/rv_alu_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rv_alu_arb
//  Description : Round-robin arbiter sharing one ALU among NREQ requesters,
//                with a single-entry response register that supports
//                zero-bubble pass-through when the consumer is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_alu_arb
  import rv_alu_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREQ = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][DW-1:0]       req_in1,
  input  logic [NREQ-1:0][DW-1:0]       req_in2,
  input  logic [NREQ-1:0][c_op_w-1:0]   req_op,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [DW-1:0]                 rsp_out,
  output logic                          rsp_zflag,
  output logic                          rsp_err
);

  localparam int c_idw = $clog2(NREQ);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              r_state;
  logic [c_idw-1:0]    r_rr_ptr;
  logic [c_idw-1:0]    r_rsp_id;
  logic [DW-1:0]       r_rsp_out;
  logic                r_rsp_zflag;
  logic                r_rsp_err;

  logic                w_gnt_any;
  logic [c_idw-1:0]    w_gnt_idx;
  logic                w_can_accept;
  logic                w_accept;
  logic [c_idw-1:0]    w_next_ptr;
  logic [DW-1:0]       w_sel_in1;
  logic [DW-1:0]       w_sel_in2;
  logic [c_op_w-1:0]   w_sel_op;
  logic [DW-1:0]       w_alu_out;
  logic                w_alu_zflag;

  // Index arithmetic modulo NREQ (operands are always below NREQ)
  function automatic int wrap_add(input int a, input int b);
    int s;
    s = a + b;
    if (s >= NREQ) s = s - NREQ;
    return s;
  endfunction

  // Search from rr_ptr upward with wrap; walking offsets high-to-low lets the
  // nearest valid requester overwrite any farther one
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_valid[c_idw'(wrap_add(int'(r_rr_ptr), off))]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = c_idw'(wrap_add(int'(r_rr_ptr), off));
      end
    end
  end

  // A slot is available when empty, or when the held result leaves this cycle
  assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;
  assign w_accept     = w_can_accept && w_gnt_any;
  assign w_next_ptr   = (w_gnt_idx == c_idw'(NREQ - 1)) ? '0 : (w_gnt_idx + c_idw'(1));

  // One-hot ready to the granted requester, forced low while reset is held
  always_comb begin
    req_ready = '0;
    if (w_accept && rst_n) req_ready[w_gnt_idx] = 1'b1;
  end

  // Only the granted requester's operands reach the ALU
  assign w_sel_in1 = req_in1[w_gnt_idx];
  assign w_sel_in2 = req_in2[w_gnt_idx];
  assign w_sel_op  = req_op[w_gnt_idx];

  rv_alu_core #(
    .DW (DW)
  ) u_core (
    .in1   (w_sel_in1),
    .in2   (w_sel_in2),
    .op    (w_sel_op),
    .out   (w_alu_out),
    .zflag (w_alu_zflag)
  );

  // Response FSM: load on grant, drain to EMPTY when consumed with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_rr_ptr    <= '0;
      r_rsp_id    <= '0;
      r_rsp_out   <= '0;
      r_rsp_zflag <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_FULL;
      r_rr_ptr    <= w_next_ptr;
      r_rsp_id    <= w_gnt_idx;
      r_rsp_out   <= w_alu_out;
      r_rsp_zflag <= w_alu_zflag;
      r_rsp_err   <= ~is_legal_op(w_sel_op);
    end else if ((r_state == ST_FULL) && rsp_ready) begin
      r_state     <= ST_EMPTY;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_id    = r_rsp_id;
  assign rsp_out   = r_rsp_out;
  assign rsp_zflag = r_rsp_zflag;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_rv_alu_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_alu_arb
//  Description : Directed self-checking bench for rv_alu_arb (NREQ=2, DW=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_alu_arb;

  localparam int DW   = 32;
  localparam int NREQ = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0][DW-1:0]  req_in1;
  logic [NREQ-1:0][DW-1:0]  req_in2;
  logic [NREQ-1:0][3:0]     req_op;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [0:0]               rsp_id;
  logic [DW-1:0]            rsp_out;
  logic                     rsp_zflag;
  logic                     rsp_err;

  int checks = 0;
  int errors = 0;

  rv_alu_arb #(.DW(DW), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_zflag (rsp_zflag),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Advance one cycle; returns on the falling edge, mid-cycle
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i]  = op;
    req_in1[i] = a;
    req_in2[i] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    set_req(0, 4'b0010, 32'd1, 32'd2);
    set_req(1, 4'b0010, 32'd3, 32'd4);
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_out !== 32'd0) begin errors++; $display("FAIL reset_out got %h exp 0", rsp_out); end
    checks++; if (rsp_zflag !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_flags got z=%b e=%b exp 0 0", rsp_zflag, rsp_err); end
    req_valid = 2'b00;
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready got %b exp 00", req_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    set_req(0, 4'b0010, 32'd5, 32'd7);
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_out !== 32'd12) begin errors++; $display("FAIL single_out got %0d exp 12", rsp_out); end
    checks++; if (rsp_zflag !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_flags got z=%b e=%b exp 0 0", rsp_zflag, rsp_err); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [0:0]  exp_id;
    logic [31:0] exp_out;
    // restart from rr_ptr=0
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 4'b0010, 32'd10, 32'd1);
    set_req(1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_id  = (k % 2 == 0) ? 1'b0 : 1'b1;
      exp_out = (k % 2 == 0) ? 32'd11 : 32'h0000_00FF;
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin errors++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d exp v=1 id=%0d", k, rsp_valid, rsp_id, exp_id); end
      checks++; if (rsp_out !== exp_out) begin errors++; $display("FAIL rr_out[%0d] got %h exp %h", k, rsp_out, exp_out); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    set_req(0, 4'b0110, 32'd3, 32'd3);
    set_req(1, 4'b0000, 32'h0000_FF00, 32'h0000_0FF0);
    req_valid = 2'b01; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      // operands wiggle while stalled; only grant-cycle values may matter
      set_req(0, 4'b0010, 32'(k + 1), 32'd9);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 00", k, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_out !== 32'd0 || rsp_zflag !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got v=%b out=%h z=%b exp v=1 out=0 z=1", k, rsp_valid, rsp_out, rsp_zflag); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_ready got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (rsp_id !== 1'b1 || rsp_out !== 32'h0000_0F00) begin errors++; $display("FAIL bp_next got id=%0d out=%h exp id=1 out=00000f00", rsp_id, rsp_out); end
    tick();
  endtask

  task automatic test_boundaries();
    logic [3:0]  v_op [5];
    logic [31:0] v_a  [5];
    logic [31:0] v_b  [5];
    logic [31:0] v_e  [5];
    logic        v_z  [5];
    v_op[0] = 4'b0010; v_a[0] = 32'hFFFF_FFFF; v_b[0] = 32'd1;          v_e[0] = 32'd0;          v_z[0] = 1'b1;
    v_op[1] = 4'b0110; v_a[1] = 32'd0;         v_b[1] = 32'd1;          v_e[1] = 32'hFFFF_FFFF;  v_z[1] = 1'b0;
    v_op[2] = 4'b0111; v_a[2] = 32'hFFFF_FFFF; v_b[2] = 32'd1;          v_e[2] = 32'd0;          v_z[2] = 1'b1;
    v_op[3] = 4'b1100; v_a[3] = 32'd0;         v_b[3] = 32'd0;          v_e[3] = 32'hFFFF_FFFF;  v_z[3] = 1'b0;
    v_op[4] = 4'b0111; v_a[4] = 32'd1;         v_b[4] = 32'hFFFF_FFFF;  v_e[4] = 32'd1;          v_z[4] = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_req(0, v_op[k], v_a[k], v_b[k]);
      req_valid = 2'b01;
      tick();
      checks++; if (rsp_out !== v_e[k] || rsp_zflag !== v_z[k]) begin errors++; $display("FAIL bound[%0d] got out=%h z=%b exp out=%h z=%b", k, rsp_out, rsp_zflag, v_e[k], v_z[k]); end
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL bound_vld[%0d] got v=%b e=%b exp v=1 e=0", k, rsp_valid, rsp_err); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b1;
    set_req(0, 4'b0011, 32'h1234_5678, 32'h1111_1111);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ill_ready got %b exp 01", req_ready); end
    tick();
    checks++; if (rsp_err !== 1'b1 || rsp_out !== 32'd0 || rsp_zflag !== 1'b1) begin errors++; $display("FAIL ill_rsp got e=%b out=%h z=%b exp e=1 out=0 z=1", rsp_err, rsp_out, rsp_zflag); end
    set_req(0, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    checks++; if (rsp_err !== 1'b1 || rsp_out !== 32'd0) begin errors++; $display("FAIL ill_rsp2 got e=%b out=%h exp e=1 out=0", rsp_err, rsp_out); end
    set_req(0, 4'b0000, 32'h0000_000F, 32'h0000_0003);
    tick();
    checks++; if (rsp_err !== 1'b0 || rsp_out !== 32'd3 || rsp_zflag !== 1'b0) begin errors++; $display("FAIL legal_after got e=%b out=%h z=%b exp e=0 out=3 z=0", rsp_err, rsp_out, rsp_zflag); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_midreset();
    set_req(0, 4'b0010, 32'd1, 32'd1);
    set_req(1, 4'b0010, 32'd100, 32'd100);
    req_valid = 2'b01; rsp_ready = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_out !== 32'd2) begin errors++; $display("FAIL mr_full got v=%b out=%h exp v=1 out=2", rsp_valid, rsp_out); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mr_stall_ready got %b exp 00", req_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_out !== 32'd0) begin errors++; $display("FAIL mr_async got v=%b out=%h exp v=0 out=0", rsp_valid, rsp_out); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mr_in_reset_ready got %b exp 00", req_ready); end
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mr_ptr_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 32'd2) begin errors++; $display("FAIL mr_after got v=%b id=%0d out=%h exp v=1 id=0 out=2", rsp_valid, rsp_id, rsp_out); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_in1 = '0; req_in2 = '0; req_op = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_boundaries();
    test_illegal();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
